trigger_encoder: RTL and testbench
==================================

Name: trigger_encoder

Overview:
- Off-chip-side encoder producing the 16-bit word stream consumed by the on-chip output decoder.
- Merges a 40 Mb/s trigger bitstream and host command words into one framed stream.
- Each 4-bit trigger window is encoded as a trigger codeword; free frame slots carry queued commands.
- Sits between the fast-command front end and the word FIFO write side.

Parameters:
CMD_FIFO_AW, 3, log2 depth of internal command FIFO (depth 8)
IDLE_WORD, 16'hAAAA, filler word emitted on empty frames (only with IDLE_WORD_EN)

Ports:
clk40  in  1  40 MHz clock; one trigger bit per cycle
rst_n  in  1  asynchronous active-low reset
trig_in  in  1  trigger bitstream; MSB of each 4-bit window arrives first
cmd_data  in  16  command word
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !full
cmd_illegal  out  1  one-cycle pulse: accepted command equalled a trigger codeword and was dropped
word_out  out  16  encoded output word
word_valid  out  1  one-cycle strobe, at most once per frame
frame_start  out  1  high when phase counter = 0
fifo_level  out  CMD_FIFO_AW+1  command FIFO occupancy

Behaviour:
- Reset (async assert, sync release): phase=0, shift reg=0, FIFO empty, word_out=16'h0000, word_valid=0, cmd_illegal=0, cmd_ready=1 after reset (0 while asserted), frame_start=1.
- Phase counter 0..3 increments every cycle and wraps 3->0. Trigger bits shift in every cycle.
- At phase 3, pattern P = {sr[2:0], trig_in}. Its first bit is P[3].
- Encoding table, P -> word:
  1->AAA2, 2->AAA4, 3->AAA8, 4->AA1A, 5->AA2A, 6->AA4A, 7->AA8A,
  8->A1AA, 9->A2AA, 10->A4AA, 11->A8AA, 12->1AAA, 13->2AAA, 14->4AAA, 15->8AAA.
  P=0 means no trigger.
- Frame decision, taken at the phase-3 edge, registered output on the next edge (phase 0); latency 1 cycle after the last trigger bit:
  - P!=0: word_out=code(P), word_valid=1. Triggers have absolute priority and are never dropped or delayed.
  - P=0 and FIFO non-empty: pop head, word_out=head, word_valid=1.
  - P=0 and FIFO empty: word_valid=0 and word_out holds its value (see Optional Feature).
- word_valid is low in phases 1..3.
- Command enqueue happens when cmd_valid && cmd_ready.
  - If cmd_data matches any of the 15 codewords, it is not written.
  - In that case cmd_illegal pulses the following cycle.
- Full FIFO: cmd_ready=0, even if a pop occurs in the same cycle. Ready is registered from the occupancy.
- Simultaneous push and pop when not full: both occur and fifo_level is unchanged.
- Command order is preserved (FIFO). Worst-case command latency: (level+1) frames while no triggers occur. It is unbounded under continuous triggers.
- Reset mid-frame discards the partial pattern and all queued commands. No word is emitted for the aborted frame.

Optional Feature:
- Macro: TRIGGER_ENCODER_IDLE_WORD_EN.
- Defined: empty frames (P=0, FIFO empty) emit word_out=IDLE_WORD with word_valid=1. word_valid then has exactly one strobe per frame, giving the receiver a continuous frame reference.
- Not defined: empty frames produce no strobe.
- Commands equal to IDLE_WORD are legal in both builds.

Decomposition:
- Shared package trig_enc_pkg:
  - codeword table constant (15 x 16 bit);
  - function encode_trig(4-bit) -> 16-bit;
  - function is_trig_word(16-bit) -> bit;
  - IDLE_WORD default value.
  The on-chip decoder reuses the table.
- One sub-module, trig_cmd_fifo: synchronous FIFO, parameterised width/AW, registered full/empty, level output, async active-low reset.

Test Plan:
- Reset, then trig_in=1,0,1,1 (P=11) in phases 0..3, FIFO empty -> next cycle word_out=A8AA, word_valid=1 for exactly one cycle; no other strobes.
- Push cmd 16'h1234 then 16'h5678 with trig_in=0 -> consecutive frames emit 1234 then 5678; fifo_level goes 2,1,0.
- Queue 16'hBEEF while trig_in=0,0,0,1 (P=1) -> AAA2 is emitted first and BEEF the following frame; order intact.
- Push 9 commands back-to-back with no pops -> cmd_ready drops after 8th accepted, fifo_level=8, 9th held until a pop frame.
- Push cmd 16'hA4AA -> not enqueued, cmd_illegal one-cycle pulse, fifo_level unchanged; push 16'hAAAA -> accepted.
- Assert rst_n low at phase 2 with 3 commands queued -> all outputs at reset values immediately; after release no stale word is emitted, fifo_level=0, phase restarts at 0. With the macro defined, empty frames after release strobe AAAA every 4 cycles.

Source files
------------

// File: rtl/trig_enc_pkg.sv
// Shared trigger codeword table and helpers; the on-chip output decoder reuses
// the same table so both ends agree on which 16-bit words are triggers.
package trig_enc_pkg;

   localparam logic [15:0] IDLE_WORD_DEF = 16'hAAAA;

   // Index is the 4-bit trigger window value P; P=0 means "no trigger" and has no entry.
   localparam logic [15:0] TRIG_CODE_TABLE [1:15] = '{
      16'hAAA2, 16'hAAA4, 16'hAAA8,
      16'hAA1A, 16'hAA2A, 16'hAA4A, 16'hAA8A,
      16'hA1AA, 16'hA2AA, 16'hA4AA, 16'hA8AA,
      16'h1AAA, 16'h2AAA, 16'h4AAA, 16'h8AAA
   };

   function automatic logic [15:0] encode_trig(input logic [3:0] pat);
      logic [15:0] word;
      if (pat == 4'd0) begin
         word = 16'h0000;
      end else begin
         word = TRIG_CODE_TABLE[pat];
      end
      return word;
   endfunction

   function automatic logic is_trig_word(input logic [15:0] word);
      logic hit;
      hit = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         hit = hit | (word == TRIG_CODE_TABLE[i]);
      end
      return hit;
   endfunction

endpackage

// File: rtl/trig_cmd_fifo.sv
// Synchronous command FIFO with registered empty/full flags and an occupancy count.
// full_next exposes the flag value that will be registered on the coming edge.
module trig_cmd_fifo #(
   parameter int W  = 16,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          empty,
   output logic          full,
   output logic          full_next,
   output logic [AW:0]   level
);

   localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

   logic [W-1:0]  mem_q [1 << AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          do_push_s, do_pop_s;

   assign do_push_s = push & ~full_q;
   assign do_pop_s  = pop & ~empty_q;

   // Pointer and occupancy update; a simultaneous push and pop leaves the level unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
      empty_d = (level_d == {(AW+1){1'b0}});
      full_d  = (level_d == FULL_LEVEL);
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {(AW+1){1'b0}};
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata     = mem_q[rd_ptr_q];
   assign empty     = empty_q;
   assign full      = full_q;
   assign full_next = full_d;
   assign level     = level_q;

endmodule

// File: rtl/trigger_encoder.sv
// Merges a 4-bit-windowed trigger bitstream and queued host commands into framed 16-bit words.
// Optional TRIGGER_ENCODER_IDLE_WORD_EN: empty frames emit IDLE_WORD so every frame strobes.
module trigger_encoder
   import trig_enc_pkg::*;
#(
   parameter int          CMD_FIFO_AW = 3,
   parameter logic [15:0] IDLE_WORD   = IDLE_WORD_DEF
) (
   input  logic                   clk40,
   input  logic                   rst_n,
   input  logic                   trig_in,
   input  logic [15:0]            cmd_data,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   output logic                   cmd_illegal,
   output logic [15:0]            word_out,
   output logic                   word_valid,
   output logic                   frame_start,
   output logic [CMD_FIFO_AW:0]   fifo_level
);

   logic [1:0]  phase_q, phase_d;
   logic [2:0]  sr_q, sr_d;
   logic [15:0] word_out_q, word_out_d;
   logic        word_valid_q, word_valid_d;
   logic        frame_start_q, frame_start_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        cmd_illegal_q, cmd_illegal_d;

   logic [3:0]  pat_s;
   logic        cmd_fire_s, cmd_bad_s, push_s, pop_s;
   logic [15:0] fifo_head_s;
   logic        fifo_empty_s, fifo_full_s, fifo_full_next_s;

   assign pat_s      = {sr_q, trig_in};
   assign cmd_fire_s = cmd_valid & cmd_ready_q;
   assign cmd_bad_s  = cmd_fire_s & is_trig_word(cmd_data);
   assign push_s     = cmd_fire_s & ~cmd_bad_s & ~fifo_full_s;

   trig_cmd_fifo #(
      .W  (16),
      .AW (CMD_FIFO_AW)
   ) u_fifo (
      .clk       (clk40),
      .rst_n     (rst_n),
      .push      (push_s),
      .wdata     (cmd_data),
      .pop       (pop_s),
      .rdata     (fifo_head_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s),
      .full_next (fifo_full_next_s),
      .level     (fifo_level)
   );

   // Frame slot decision at the last phase: trigger first, then a queued command, else idle.
   always_comb begin
      word_out_d   = word_out_q;
      word_valid_d = 1'b0;
      pop_s        = 1'b0;
      if (phase_q == 2'd3) begin
         if (pat_s != 4'd0) begin
            word_out_d   = encode_trig(pat_s);
            word_valid_d = 1'b1;
         end else if (!fifo_empty_s) begin
            word_out_d   = fifo_head_s;
            word_valid_d = 1'b1;
            pop_s        = 1'b1;
         end else begin
`ifdef TRIGGER_ENCODER_IDLE_WORD_EN
            word_out_d   = IDLE_WORD;
            word_valid_d = 1'b1;
`else
            word_out_d   = word_out_q;
            word_valid_d = 1'b0;
`endif
         end
      end else begin
         word_valid_d = 1'b0;
      end
   end

   // Framing counter, trigger shift register and command-side handshake flags.
   always_comb begin
      phase_d       = phase_q + 2'd1;
      sr_d          = {sr_q[1:0], trig_in};
      frame_start_d = (phase_d == 2'd0);
      cmd_illegal_d = cmd_bad_s;
   end

   // Ready follows the occupancy the FIFO will hold after this edge, so it stays low for a full cycle.
   assign cmd_ready_d = ~fifo_full_next_s;

   // All output and framing registers; reset discards any partial trigger window.
   always_ff @(posedge clk40 or negedge rst_n) begin
      if (!rst_n) begin
         phase_q       <= 2'd0;
         sr_q          <= 3'd0;
         word_out_q    <= 16'h0000;
         word_valid_q  <= 1'b0;
         frame_start_q <= 1'b1;
         cmd_ready_q   <= 1'b0;
         cmd_illegal_q <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         sr_q          <= sr_d;
         word_out_q    <= word_out_d;
         word_valid_q  <= word_valid_d;
         frame_start_q <= frame_start_d;
         cmd_ready_q   <= cmd_ready_d;
         cmd_illegal_q <= cmd_illegal_d;
      end
   end

   assign word_out    = word_out_q;
   assign word_valid  = word_valid_q;
   assign frame_start = frame_start_q;
   assign cmd_ready   = cmd_ready_q;
   assign cmd_illegal = cmd_illegal_q;

endmodule

// File: tb/tb_trigger_encoder.sv
// Scoreboard bench for trigger_encoder: a frame-level reference model queues expected words
// as stimulus is driven; DUT strobes pop and compare them. Honours TRIGGER_ENCODER_IDLE_WORD_EN.
module tb_trigger_encoder;

   logic        clk40 = 1'b0;
   logic        rst_n = 1'b0;
   logic        trig_in = 1'b0;
   logic [15:0] cmd_data = 16'h0000;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_illegal;
   logic [15:0] word_out;
   logic        word_valid;
   logic        frame_start;
   logic [3:0]  fifo_level;

   always #5 clk40 = ~clk40;

   trigger_encoder dut (
      .clk40       (clk40),
      .rst_n       (rst_n),
      .trig_in     (trig_in),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_illegal (cmd_illegal),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .frame_start (frame_start),
      .fifo_level  (fifo_level)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] m_fifo[$];
   int          m_phase;
   logic [2:0]  m_sr;
   logic        m_ready;
   logic        m_illegal;
   logic [15:0] m_last;
   logic        m_accepted;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_code(input logic [3:0] p);
      case (p)
         4'd1:    return 16'hAAA2;
         4'd2:    return 16'hAAA4;
         4'd3:    return 16'hAAA8;
         4'd4:    return 16'hAA1A;
         4'd5:    return 16'hAA2A;
         4'd6:    return 16'hAA4A;
         4'd7:    return 16'hAA8A;
         4'd8:    return 16'hA1AA;
         4'd9:    return 16'hA2AA;
         4'd10:   return 16'hA4AA;
         4'd11:   return 16'hA8AA;
         4'd12:   return 16'h1AAA;
         4'd13:   return 16'h2AAA;
         4'd14:   return 16'h4AAA;
         4'd15:   return 16'h8AAA;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic ref_is_code(input logic [15:0] w);
      for (int p = 1; p < 16; p++) begin
         if (w == ref_code(4'(p))) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_fifo.delete();
      m_phase    = 0;
      m_sr       = 3'd0;
      m_ready    = 1'b0;
      m_illegal  = 1'b0;
      m_last     = 16'h0000;
      m_accepted = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, then sample the DUT at the falling edge.
   task automatic step(input logic t, input logic cv, input logic [15:0] cd);
      logic [3:0] pat;
      logic       fire;
      logic       exp_v;
      logic [15:0] exp_w;
      trig_in   = t;
      cmd_valid = cv;
      cmd_data  = cd;
      fire       = cv && m_ready;
      m_accepted = fire && !ref_is_code(cd);
      if (m_phase == 3) begin
         pat = {m_sr, t};
         if (pat != 4'd0) begin
            exp_q.push_back(ref_code(pat));
         end else if (m_fifo.size() > 0) begin
            exp_q.push_back(m_fifo.pop_front());
         end else begin
`ifdef TRIGGER_ENCODER_IDLE_WORD_EN
            exp_q.push_back(16'hAAAA);
`endif
         end
      end
      if (m_accepted) m_fifo.push_back(cd);
      m_illegal = fire && ref_is_code(cd);
      m_ready   = (m_fifo.size() < 8);
      m_sr      = {m_sr[1:0], t};
      m_phase   = (m_phase + 1) % 4;
      @(posedge clk40);
      @(negedge clk40);
      exp_v = (exp_q.size() > 0);
      check_val("word_valid", {31'd0, word_valid}, {31'd0, exp_v});
      if (exp_v) begin
         exp_w  = exp_q.pop_front();
         m_last = exp_w;
         check_val("word_out", {16'd0, word_out}, {16'd0, exp_w});
      end else begin
         check_val("word_hold", {16'd0, word_out}, {16'd0, m_last});
      end
      check_val("frame_start", {31'd0, frame_start}, {31'd0, (m_phase == 0)});
      check_val("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
      check_val("cmd_illegal", {31'd0, cmd_illegal}, {31'd0, m_illegal});
      check_val("fifo_level", {28'd0, fifo_level}, 32'(m_fifo.size()));
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      trig_in   = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = 16'h0000;
      #1;
      check_val("rst_word_out", {16'd0, word_out}, 32'h0);
      check_val("rst_word_valid", {31'd0, word_valid}, 32'h0);
      check_val("rst_cmd_illegal", {31'd0, cmd_illegal}, 32'h0);
      check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'h0);
      check_val("rst_frame_start", {31'd0, frame_start}, 32'h1);
      check_val("rst_fifo_level", {28'd0, fifo_level}, 32'h0);
      model_reset();
      @(negedge clk40);
      @(negedge clk40);
      rst_n = 1'b1;
   endtask

   task automatic align_frame();
      while (m_phase != 0) step(1'b0, 1'b0, 16'h0000);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      model_reset();
      @(negedge clk40);
      apply_reset();

      // Single trigger window 1,0,1,1 -> A8AA, then quiet frames.
      step(1'b1, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 16'h0000);
      idle(8);

      // Two commands drain in order on consecutive empty frames.
      step(1'b0, 1'b1, 16'h1234);
      step(1'b0, 1'b1, 16'h5678);
      idle(10);

      // Trigger in the same frame as a queued command takes the slot first.
      align_frame();
      step(1'b0, 1'b1, 16'hBEEF);
      step(1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 16'h0000);
      idle(8);

      // Fill the FIFO under continuous triggers, then let a pop admit the ninth command.
      align_frame();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h0100 + i));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h0109);
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 1'b1, 16'h0109);
         if (m_accepted) break;
      end
      check_val("cmd9_accepted", {31'd0, m_accepted}, 32'h1);
      idle(44);

      // Codeword-valued command is dropped; the idle-word value is an ordinary command.
      step(1'b0, 1'b1, 16'hA4AA);
      step(1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b1, 16'hAAAA);
      idle(10);

      // Reset mid-frame with three commands queued.
      align_frame();
      step(1'b1, 1'b1, 16'h0A01);
      step(1'b1, 1'b1, 16'h0A02);
      step(1'b1, 1'b1, 16'h0A03);
      step(1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 16'h0000);
      apply_reset();
      idle(12);

      // Randomised mix of triggers and commands, some of them illegal codewords.
      for (int i = 0; i < 200; i++) begin
         logic        t;
         logic        cv;
         logic [15:0] cd;
         t  = ($urandom_range(0, 3) == 0);
         cv = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 5) == 0) cd = ref_code(4'($urandom_range(1, 15)));
         else cd = 16'($urandom);
         step(t, cv, cd);
      end
      idle(48);

      check_val("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
